// File: rtl/event_led_pkg.sv
// -----------------------------------------------------------------------------
// event_led_pkg
//
// Purpose : Shared types and elaboration-time helpers for the event_led LED
//           blinker and its ms_timer sub-block.
//
// Contents:
//   state_t    - blink sequencer states (idle, LED on-phase, dark gap)
//   max_int    - larger of two integers, used to size the shared timer
//   cnt_width  - bits needed to hold the values 0..n-1 (never less than 1)
// -----------------------------------------------------------------------------
package event_led_pkg;

    // Blink sequencer states. IDLE is the all-zero encoding so that a cleared
    // state register is automatically the quiescent state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // Larger of two integers.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter covering 0..n-1. This is $clog2(n), except that it
    // never collapses to zero bits when n is 1 or 2, so a degenerate
    // one-cycle phase still produces a legal one-bit vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : event_led_pkg

// File: rtl/ms_timer.sv
// -----------------------------------------------------------------------------
// ms_timer
//
// Purpose : Loadable down-counter with a zero flag. Intended as a reusable
//           building block for ms-scale timing (blink phases, holdoffs, ...).
//           The counter stops at zero; it never wraps.
//
// Parameters:
//   WIDTH       - counter width in bits
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset (counter -> 0)
//   i_load      in   load i_load_val this cycle (takes priority over i_dec)
//   i_load_val  in   value to load
//   i_dec       in   decrement by one this cycle (ignored when already zero)
//   o_zero      out  high while the count is zero
// -----------------------------------------------------------------------------
module ms_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);
    assign o_zero = w_zero;

    // NOTE: clocked state is written only with non-blocking assignments so
    // every register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !w_zero) begin
            // Saturate at zero rather than wrapping to all-ones.
            r_count <= r_count - 1'b1;
        end
    end

endmodule : ms_timer

// File: rtl/event_led.sv
// -----------------------------------------------------------------------------
// event_led
//
// Purpose : Turns single-cycle event strobes into human-visible LED blinks
//           with a guaranteed minimum on-time and a mandatory dark gap after
//           every blink. Events arriving while a blink is in progress are
//           queued in a saturating pending counter and replayed as
//           back-to-back blinks; an event that would overflow the queue is
//           dropped and reported with a one-cycle overflow pulse.
//
// Parameters:
//   CLK_FREQ     - clock frequency in kHz (cycles per ms)
//   ON_MS        - LED on-time per blink, ms
//   OFF_MS       - dark gap after each blink, ms
//   MAX_PENDING  - maximum number of queued events (>= 1)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   event_in     in   event strobe; every high cycle is one event
//   led_out      out  registered LED drive, high during the on-phase
//   busy         out  high while a blink/gap is running or events are queued
//   overflow     out  registered one-cycle pulse when an event is dropped
//
// Timing: an event sampled at edge N while idle gives led_out high for
// cycles N+1..N+ON_CYCLES, then low for OFF_CYCLES cycles. A queued blink
// rises exactly ON_CYCLES+OFF_CYCLES cycles after the previous rise.
// -----------------------------------------------------------------------------
module event_led
    import event_led_pkg::*;
#(
    parameter int CLK_FREQ    = 95000,
    parameter int ON_MS       = 50,
    parameter int OFF_MS      = 50,
    parameter int MAX_PENDING = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic event_in,
    output logic led_out,
    output logic busy,
    output logic overflow
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int ON_CYCLES  = ON_MS  * CLK_FREQ;
    localparam int OFF_CYCLES = OFF_MS * CLK_FREQ;

    // One timer serves both phases, so it is sized for the longer one.
    localparam int TIMER_W = cnt_width(max_int(ON_CYCLES, OFF_CYCLES));
    localparam int PEND_W  = cnt_width(MAX_PENDING + 1);

    // The timer counts down to zero inclusive, so a phase of N cycles loads N-1.
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);

    // -------------------------------------------------------------------------
    // Registers and combinational nets
    // -------------------------------------------------------------------------
    state_t              r_state;
    logic [PEND_W-1:0]   r_pending;
    logic                r_led;
    logic                r_overflow;

    state_t              w_next_state;
    logic                w_timer_load;
    logic [TIMER_W-1:0]  w_timer_load_val;
    logic                w_timer_zero;
    logic                w_start;          // a new blink begins at this edge
    logic                w_have_pending;
    logic                w_take_queued;    // this start consumes a queued event
    logic                w_enqueue;        // event_in must go into the queue
    logic [PEND_W-1:0]   w_pending_next;
    logic                w_drop;

    assign w_have_pending = (r_pending != '0);

    // -------------------------------------------------------------------------
    // Phase timer: runs whenever a blink or its gap is in progress
    // -------------------------------------------------------------------------
    ms_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_load_val),
        .i_dec      (r_state != ST_IDLE),
        .o_zero     (w_timer_zero)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state     = r_state;
        w_timer_load     = 1'b0;
        w_timer_load_val = ON_LOAD;
        w_start          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (event_in || w_have_pending) begin
                    w_next_state = ST_ON;
                    w_timer_load = 1'b1;
                    w_start      = 1'b1;
                end
            end

            ST_ON: begin
                if (w_timer_zero) begin
                    w_next_state     = ST_OFF;
                    w_timer_load     = 1'b1;
                    w_timer_load_val = OFF_LOAD;
                end
            end

            ST_OFF: begin
                if (w_timer_zero) begin
                    // Chaining straight from the last gap cycle into the next
                    // on-phase avoids an extra idle cycle between blinks.
                    if (event_in || w_have_pending) begin
                        w_next_state = ST_ON;
                        w_timer_load = 1'b1;
                        w_start      = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pending-queue accounting
    // -------------------------------------------------------------------------
    // A start serves the queue first. Only when the queue is empty does the
    // start swallow the incoming event directly; otherwise that event joins
    // the queue, and a simultaneous take plus enqueue leaves the count as is.
    assign w_take_queued = w_start && w_have_pending;
    assign w_enqueue     = event_in && !(w_start && !w_have_pending);

    always_comb begin
        w_pending_next = r_pending;
        w_drop         = 1'b0;

        if (w_enqueue && !w_take_queued) begin
            if (r_pending == PEND_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_pending_next = r_pending + 1'b1;
            end
        end else if (w_take_queued && !w_enqueue) begin
            w_pending_next = r_pending - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the asynchronous reset clears every register here, so the LED
    // goes dark and the queue is discarded the moment rst rises, without
    // waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_led      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pending  <= w_pending_next;
            // Registered from the next state so led_out tracks the on-phase
            // with no decode glitches on the pin.
            r_led      <= (w_next_state == ST_ON);
            r_overflow <= w_drop;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign led_out  = r_led;
    assign overflow = r_overflow;
    assign busy     = (r_state != ST_IDLE) || w_have_pending;

endmodule : event_led

// File: tb/tb_event_led.sv
// -----------------------------------------------------------------------------
// tb_event_led
//
// Self-checking bench for event_led with ON=4, OFF=3 cycles, max_pending=2.
// The reference model works in absolute cycle numbers: it remembers when the
// last blink rose and the first edge at which a new blink may start, plus a
// plain integer count of queued events. From that it predicts led_out, busy,
// overflow and the queue depth every cycle.
// -----------------------------------------------------------------------------
module tb_event_led;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int MAXP  = 2;

    logic clk;
    logic rst;
    logic event_in;
    logic led_out;
    logic busy;
    logic overflow;

    event_led #(
        .CLK_FREQ    (1),
        .ON_MS       (ON_C),
        .OFF_MS      (OFF_C),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .event_in (event_in),
        .led_out  (led_out),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int          n_checks = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          n_ovf    = 0;
    logic [31:0] hist     = '0;

    // Reference model state
    int m_last_rise = -1000;  // cycle in which the latest blink went high
    int m_next_free = 0;      // first edge at which a new blink may start
    int m_pending   = 0;
    int m_ovf       = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
                     tag, got, exp, cyc, $time);
        end
    endtask

    function automatic int exp_led();
        return (cyc >= m_last_rise && cyc < m_last_rise + ON_C) ? 1 : 0;
    endfunction

    function automatic int exp_busy();
        return (cyc < m_last_rise + ON_C + OFF_C || m_pending > 0) ? 1 : 0;
    endfunction

    // Advance the model across the edge that ends cycle 'cyc'.
    task automatic model_edge(input logic e);
        bit start, take, inc;
        start = (cyc >= m_next_free) && (m_pending > 0 || e);
        take  = start && (m_pending > 0);
        inc   = e && !(start && m_pending == 0);
        m_ovf = 0;
        if (start) begin
            m_last_rise = cyc + 1;
            m_next_free = cyc + ON_C + OFF_C;
        end
        if (inc && !take) begin
            if (m_pending == MAXP) m_ovf = 1;
            else                   m_pending++;
        end else if (take && !inc) begin
            m_pending--;
        end
    endtask

    task automatic model_reset();
        m_last_rise = -1000;
        m_next_free = 0;
        m_pending   = 0;
        m_ovf       = 0;
    endtask

    // Called at a falling edge: check this cycle's outputs, then drive the
    // event for this cycle and move to the next falling edge.
    task automatic step(input logic e);
        check("led",      int'(led_out),      exp_led());
        check("busy",     int'(busy),         exp_busy());
        check("overflow", int'(overflow),     m_ovf);
        check("pending",  int'(dut.r_pending), m_pending);
        if (cyc < 32) hist[cyc] = led_out;
        if (overflow) n_ovf++;
        event_in = e;
        model_edge(e);
        @(posedge clk);
        @(negedge clk);
        event_in = 1'b0;
        cyc++;
    endtask

    // Asynchronous reset raised between clock edges; outputs must clear
    // immediately, not at the next edge.
    task automatic apply_reset();
        event_in = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_led",      int'(led_out),       0);
        check("rst_busy",     int'(busy),          0);
        check("rst_overflow", int'(overflow),      0);
        check("rst_pending",  int'(dut.r_pending), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        cyc   = 0;
        hist  = '0;
        n_ovf = 0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        event_in = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single event: LED high 1-4, busy through 7.
        step(1'b1);
        repeat (11) step(1'b0);
        check("single_trace", int'(hist), 32'h0000_001E);

        // Queued event: second blink 8-11.
        apply_reset();
        step(1'b1); step(1'b0); step(1'b1);
        repeat (13) step(1'b0);
        check("queued_trace", int'(hist), 32'h0000_0F1E);

        // Overflow: four events back-to-back, one dropped, three blinks.
        apply_reset();
        repeat (4) step(1'b1);
        repeat (22) step(1'b0);
        check("ovf_trace", int'(hist), 32'h0007_8F1E);
        check("ovf_pulses", n_ovf, 1);

        // Event on the last gap cycle with an empty queue.
        apply_reset();
        step(1'b1);
        repeat (6) step(1'b0);
        step(1'b1);
        repeat (12) step(1'b0);
        check("coincide_trace", int'(hist), 32'h0000_0F1E);
        check("coincide_pulses", n_ovf, 0);

        // Queued event plus a new event on the last gap cycle.
        apply_reset();
        step(1'b1); step(1'b0); step(1'b1);
        repeat (4) step(1'b0);
        step(1'b1);
        repeat (14) step(1'b0);
        check("simul_trace", int'(hist), 32'h0007_8F1E);

        // Reset in the middle of a blink with an event queued.
        apply_reset();
        step(1'b1); step(1'b0); step(1'b1);
        apply_reset();
        repeat (20) step(1'b0);
        check("post_rst_trace", int'(hist), 0);

        // Randomized traffic at three densities with occasional resets.
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            int prob;
            prob = (r == 0) ? 10 : (r == 1) ? 40 : 85;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(199) == 0) apply_reset();
                step(logic'($urandom_range(99) < prob));
            end
        end
        repeat (40) step(1'b0);
        check("drained_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_event_led
